// File: rtl/sfu_pkg.sv
// Shared definitions for the special-function accumulator: FSM encoding,
// accumulator guard width and the output saturate/ReLU helper.
package sfu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAST,
    S_WR,
    S_DONE
  } sfu_state_t;

  localparam int ACC_EXT = 8;

  // Clamp a wide signed value into a signed field of 'width' bits, then
  // optionally force negatives to zero; the caller truncates the result.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] value,
                                                   input int width,
                                                   input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      r = hi;
    end else if (value < lo) begin
      r = lo;
    end else begin
      r = value;
    end
    if (relu && (r < 64'sd0)) begin
      r = 64'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sfu_accumulator_if.sv
// Handshake and SRAM-port bundle between the MAC controller / SRAMs and the
// special-function accumulator.
interface sfu_accumulator_if #(
  parameter int col    = 8,
  parameter int psum_bw = 16,
  parameter int ADDR_W = 11
);

  logic                    sfu_start;
  logic [7:0]              num_nij;
  logic [7:0]              num_kij;
  logic [ADDR_W-1:0]       psum_base_addr;
  logic [ADDR_W-1:0]       out_base_addr;
  logic                    relu_en;
  logic                    sfu_active;

  logic                    psum_rd;
  logic [ADDR_W-1:0]       psum_addr;
  logic [col*psum_bw-1:0]  psum_q;

  logic                    out_wr;
  logic [ADDR_W-1:0]       out_addr;
  logic [col*psum_bw-1:0]  out_d;

  modport master (
    output sfu_start, num_nij, num_kij, psum_base_addr, out_base_addr, relu_en,
    output psum_q,
    input  sfu_active, psum_rd, psum_addr, out_wr, out_addr, out_d
  );

  modport slave (
    input  sfu_start, num_nij, num_kij, psum_base_addr, out_base_addr, relu_en,
    input  psum_q,
    output sfu_active, psum_rd, psum_addr, out_wr, out_addr, out_d
  );

endinterface

// File: rtl/sfu_lane.sv
// One signed accumulator lane: clears, adds sign-extended partial sums and
// registers the saturated (optionally ReLU'd) result for the output write.
module sfu_lane
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      add,
  input  logic                      load,
  input  logic                      relu_en,
  input  logic signed [psum_bw-1:0] din,
  output logic signed [psum_bw-1:0] result
);

  localparam int AW = psum_bw + ACC_EXT;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] din_ext;
  logic signed [AW-1:0] sum;

  assign din_ext = {{ACC_EXT{din[psum_bw-1]}}, din};
  assign sum     = acc + din_ext;

  // The result register is loaded from the sum so the final word is included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (add) begin
        acc <= sum;
      end
      if (load) begin
        result <= psum_bw'(sat_relu(64'(sum), psum_bw, relu_en));
      end
    end
  end

endmodule

// File: rtl/sfu_accumulator.sv
// Accumulates per-kij partial sums from PSUM SRAM into one saturated vector per
// output pixel and writes it to output SRAM; answers the sfu_start/sfu_active handshake.
module sfu_accumulator
  import sfu_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int ADDR_W  = 11
) (
  input  logic               clk,
  input  logic               reset,
  sfu_accumulator_if.slave   bus
);

  sfu_state_t state, state_next;

  logic [7:0]             n_cfg;
  logic [7:0]             k_cfg;
  logic [ADDR_W-1:0]      pbase_cfg;
  logic [ADDR_W-1:0]      obase_cfg;
  logic                   relu_cfg;

  logic [7:0]             o_cnt, o_next;
  logic [7:0]             k_cnt, k_next;

  logic                   active_q, active_next;
  logic                   rd_q, rd_next;
  logic                   wr_q, wr_next;
  logic [ADDR_W-1:0]      raddr_q, raddr_next;
  logic [ADDR_W-1:0]      waddr_q, waddr_next;

  logic                   start_ok;
  logic                   lane_clear;
  logic                   lane_add;
  logic                   lane_load;
  logic [col*psum_bw-1:0] out_d_w;

  assign start_ok = (state == S_IDLE) && bus.sfu_start;

  // Read addresses step by N within an output and restart at base+o for the next
  // one, so no multiplier is needed; ADDR_W truncation gives the wrap.
  always_comb begin
    state_next = state;
    o_next     = o_cnt;
    k_next     = k_cnt;
    raddr_next = raddr_q;
    waddr_next = waddr_q;
    unique case (state)
      S_IDLE: begin
        if (bus.sfu_start) begin
          o_next = 8'd0;
          k_next = 8'd0;
          if ((bus.num_nij == 8'd0) || (bus.num_kij == 8'd0)) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RD;
            raddr_next = bus.psum_base_addr;
          end
        end
      end
      S_RD: begin
        if (k_cnt == (k_cfg - 8'd1)) begin
          state_next = S_LAST;
        end else begin
          k_next     = k_cnt + 8'd1;
          raddr_next = raddr_q + ADDR_W'(n_cfg);
        end
      end
      S_LAST: begin
        state_next = S_WR;
        waddr_next = obase_cfg + ADDR_W'(o_cnt);
      end
      S_WR: begin
        if (o_cnt == (n_cfg - 8'd1)) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RD;
          o_next     = o_cnt + 8'd1;
          k_next     = 8'd0;
          raddr_next = pbase_cfg + ADDR_W'(o_cnt + 8'd1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    rd_next     = (state_next == S_RD);
    wr_next     = (state_next == S_WR);
    active_next = (state_next == S_RD) || (state_next == S_LAST) || (state_next == S_WR) ||
                  ((state == S_IDLE) && (state_next == S_DONE));

    lane_clear = (state == S_RD) && (k_cnt == 8'd0);
    lane_add   = ((state == S_RD) && (k_cnt != 8'd0)) || (state == S_LAST);
    lane_load  = (state == S_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      n_cfg     <= '0;
      k_cfg     <= '0;
      pbase_cfg <= '0;
      obase_cfg <= '0;
      relu_cfg  <= 1'b0;
      o_cnt     <= '0;
      k_cnt     <= '0;
      active_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
    end else begin
      state    <= state_next;
      o_cnt    <= o_next;
      k_cnt    <= k_next;
      active_q <= active_next;
      rd_q     <= rd_next;
      wr_q     <= wr_next;
      raddr_q  <= raddr_next;
      waddr_q  <= waddr_next;
      if (start_ok) begin
        n_cfg     <= bus.num_nij;
        k_cfg     <= bus.num_kij;
        pbase_cfg <= bus.psum_base_addr;
        obase_cfg <= bus.out_base_addr;
        relu_cfg  <= bus.relu_en;
      end
    end
  end

  for (genvar c = 0; c < col; c++) begin : g_lane
    sfu_lane #(
      .psum_bw (psum_bw)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (lane_clear),
      .add     (lane_add),
      .load    (lane_load),
      .relu_en (relu_cfg),
      .din     (bus.psum_q[c*psum_bw +: psum_bw]),
      .result  (out_d_w[c*psum_bw +: psum_bw])
    );
  end

  assign bus.sfu_active = active_q;
  assign bus.psum_rd    = rd_q;
  assign bus.psum_addr  = raddr_q;
  assign bus.out_wr     = wr_q;
  assign bus.out_addr   = waddr_q;
  assign bus.out_d      = out_d_w;

endmodule
